rob: RTL and testbench
======================

# rob

Reorder buffer at the back end of the out-of-order pipeline: the in-order consumer of what the rename stage produces. Rename allocates one entry per renamed instruction in program order. Execution units mark entries complete out of order by tag. The block retires completed entries strictly in order, reporting the committed architectural mapping and the stale physical register that goes back to the free list.

## Interface
Parameters:
- PREG_WIDTH, 6, physical register index width
- AREG_WIDTH, 5, architectural register index width
- PC_WIDTH, 12, PC width
- ENTRIES, 16, buffer depth (power of two)
- TAG_WIDTH, 4, log2(ENTRIES)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- alloc_valid  in  1  rename presents an instruction
- alloc_ready  out  1  entry available (= !full)
- alloc_has_rd  in  1  instruction writes a destination
- alloc_areg  in  AREG_WIDTH  architectural destination
- alloc_preg  in  PREG_WIDTH  newly mapped physical destination
- alloc_old_preg  in  PREG_WIDTH  previous mapping of alloc_areg
- alloc_pc  in  PC_WIDTH  instruction PC
- alloc_tag  out  TAG_WIDTH  tag assigned on this alloc (= tail pointer)
- wb0_valid, wb1_valid  in  1  completion strobes, two writeback ports
- wb0_tag, wb1_tag  in  TAG_WIDTH  completing entry tag
- commit_valid  out  1  registered, one-cycle retire pulse
- commit_has_rd  out  1  retired instruction wrote a destination
- commit_areg  out  AREG_WIDTH  retired architectural destination
- commit_preg  out  PREG_WIDTH  retired physical destination
- commit_free_preg  out  PREG_WIDTH  stale preg returned to free list
- commit_pc  out  PC_WIDTH  retired PC
- count  out  TAG_WIDTH+1  occupied entries
- empty  out  1  count == 0

## Operation
- Storage per entry: valid, complete, has_rd, areg, preg, old_preg, pc.
- Circular buffer with head (oldest) and tail (next free) pointers. Both wrap modulo ENTRIES. A separate count register removes full/empty ambiguity. full = (count == ENTRIES).
- Allocate on an edge where alloc_valid && alloc_ready: write the entry at tail with valid=1 and complete=0, then tail++.
- Writeback on an edge where wbN_valid: set complete on entry wbN_tag only if that entry is valid; otherwise the strobe is ignored. Both ports may hit the same tag in the same cycle; the result is simply complete=1.
- Retire: on an edge where the head entry is valid && complete:
  - clear its valid bit and increment head;
  - register its fields onto commit_* with commit_valid=1.
- On any other edge, commit_valid=0 and the commit data outputs hold their last values.
- Retire width is one per cycle. There is no downstream backpressure.
- count next = count + alloc_fire - retire_fire. Simultaneous alloc and retire leaves count unchanged.
- When has_rd=0, commit_free_preg is still driven from the stored field. The free list must gate on commit_has_rd.

## Timing
- Reset (rst low, asynchronous):
  - head, tail, count = 0;
  - all valid and complete bits = 0;
  - commit_valid = 0 and all commit_* data = 0;
  - empty = 1, alloc_ready = 1, alloc_tag = 0.
- Removing reset mid-operation discards all entries; nothing retires from before the reset.
- alloc_ready, alloc_tag, count and empty are combinational from registered state only. They have no path from alloc_valid or wb inputs.
- Full: alloc_ready=0 even if a retire happens in the same cycle. The freed slot becomes available the next cycle.
- Latency and bypassing:
  - alloc at edge N: a writeback is accepted at edge N+1 at the earliest.
  - writeback at edge M on the head entry: that entry retires at edge M+1, and commit_valid is high in the cycle after edge M+1.
  - There is no same-edge writeback-to-retire bypass.
- A writeback targeting the tag being allocated on the same edge is ignored, because the entry is not yet valid.
- Back-to-back retires run at one per cycle while successive head entries are complete.

## Structure
- Shared header (cpu_params.vh) holds PREG_WIDTH, AREG_WIDTH, PC_WIDTH, ROB_ENTRIES and ROB_TAG_WIDTH. Rename and the execution units use the same values.
- One natural sub-module: rob_ptr, a wrapping pointer/count unit that produces head, tail, count, full and empty from the alloc and retire fire signals.
- The entry array and writeback/retire logic stay in rob.

## Test plan
- Reset, then alloc 3 entries (areg 1/2/3, preg 33/34/35, old 1/2/3), then wb tags 0,1,2 in order → three consecutive commit_valid pulses with preg 33,34,35 and free_preg 1,2,3.
- Alloc tags 0–2, then wb tag 2, then tag 1 → no commit until wb tag 0; then tags 0,1,2 retire on three consecutive cycles.
- Alloc 16 without wb → count=16, alloc_ready=0, and a 17th alloc_valid is not accepted. wb tag 0 → retire; alloc_ready returns the cycle after the retire edge; the new alloc_tag is 0 (wrap).
- wb0_tag = wb1_tag = 0 in the same cycle on a valid head → exactly one commit. A wb to an invalid tag (5, buffer holds 2) → no state change, no commit.
- Steady state with one alloc and one retire per cycle → count constant across pointer wrap, commit PCs in allocation order.
- Assert rst mid-stream with 6 entries pending → commit_valid drops immediately, count=0, empty=1; later wb strobes to old tags produce no commits.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared ROB sizing, used by rename, the execution units and the reorder buffer itself.
package rob_pkg;

  localparam int CPU_PREG_WIDTH    = 6;
  localparam int CPU_AREG_WIDTH    = 5;
  localparam int CPU_PC_WIDTH      = 12;
  localparam int CPU_ROB_ENTRIES   = 16;
  localparam int CPU_ROB_TAG_WIDTH = 4;

  // Tags double as buffer indices, so the depth has to be exactly 2**TAG_WIDTH.
  function automatic bit rob_geometry_ok(input int entries, input int tag_width);
    return entries == (1 << tag_width);
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Head/tail/count bookkeeping for the reorder buffer's circular storage.
module rob_ptr
  import rob_pkg::*;
#(
  parameter int ENTRIES   = CPU_ROB_ENTRIES,
  parameter int TAG_WIDTH = CPU_ROB_TAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_fire,
  input  logic                 retire_fire,
  output logic [TAG_WIDTH-1:0] head,
  output logic [TAG_WIDTH-1:0] tail,
  output logic [TAG_WIDTH:0]   count,
  output logic                 full,
  output logic                 empty
);

  // Pointers wrap naturally because the depth is a power of two; count breaks the full/empty tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire) tail <= tail + TAG_WIDTH'(1);
      if (retire_fire) head <= head + TAG_WIDTH'(1);
      case ({alloc_fire, retire_fire})
        2'b10:   count <= count + (TAG_WIDTH+1)'(1);
        2'b01:   count <= count - (TAG_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Status flags come from registered state only.
  always_comb begin
    full  = (count == (TAG_WIDTH+1)'(ENTRIES));
    empty = (count == '0);
  end

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocation from rename, out-of-order completion, in-order retire.
module rob
  import rob_pkg::*;
#(
  parameter int PREG_WIDTH = CPU_PREG_WIDTH,
  parameter int AREG_WIDTH = CPU_AREG_WIDTH,
  parameter int PC_WIDTH   = CPU_PC_WIDTH,
  parameter int ENTRIES    = CPU_ROB_ENTRIES,
  parameter int TAG_WIDTH  = CPU_ROB_TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic                  alloc_has_rd,
  input  logic [AREG_WIDTH-1:0] alloc_areg,
  input  logic [PREG_WIDTH-1:0] alloc_preg,
  input  logic [PREG_WIDTH-1:0] alloc_old_preg,
  input  logic [PC_WIDTH-1:0]   alloc_pc,
  output logic [TAG_WIDTH-1:0]  alloc_tag,
  input  logic                  wb0_valid,
  input  logic                  wb1_valid,
  input  logic [TAG_WIDTH-1:0]  wb0_tag,
  input  logic [TAG_WIDTH-1:0]  wb1_tag,
  output logic                  commit_valid,
  output logic                  commit_has_rd,
  output logic [AREG_WIDTH-1:0] commit_areg,
  output logic [PREG_WIDTH-1:0] commit_preg,
  output logic [PREG_WIDTH-1:0] commit_free_preg,
  output logic [PC_WIDTH-1:0]   commit_pc,
  output logic [TAG_WIDTH:0]    count,
  output logic                  empty
);

  logic [TAG_WIDTH-1:0]  head;
  logic [TAG_WIDTH-1:0]  tail;
  logic                  full;
  logic                  alloc_fire;
  logic                  retire_fire;
  logic [ENTRIES-1:0]    valid_q;
  logic [ENTRIES-1:0]    complete_q;
  logic [ENTRIES-1:0]    wb_hit;
  logic                  has_rd_q   [ENTRIES];
  logic [AREG_WIDTH-1:0] areg_q     [ENTRIES];
  logic [PREG_WIDTH-1:0] preg_q     [ENTRIES];
  logic [PREG_WIDTH-1:0] old_preg_q [ENTRIES];
  logic [PC_WIDTH-1:0]   pc_q       [ENTRIES];

  rob_ptr #(
    .ENTRIES   (ENTRIES),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_ptr (
    .clk         (clk),
    .rst         (rst),
    .alloc_fire  (alloc_fire),
    .retire_fire (retire_fire),
    .head        (head),
    .tail        (tail),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  // Handshake and retire decisions; ready depends only on the registered count, so a same-cycle retire never frees a slot early.
  always_comb begin
    alloc_ready = !full;
    alloc_tag   = tail;
    alloc_fire  = alloc_valid && !full;
    retire_fire = valid_q[head] && complete_q[head];
  end

  // A writeback strobe only lands on an entry that is already valid, which also drops strobes aimed at the slot being allocated.
  always_comb begin
    wb_hit = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      wb_hit[i] = valid_q[i] &&
                  ((wb0_valid && (wb0_tag == TAG_WIDTH'(i))) ||
                   (wb1_valid && (wb1_tag == TAG_WIDTH'(i))));
    end
  end

  // Per-entry valid/complete tracking: allocate at tail, complete on writeback, release at head on retire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      complete_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (alloc_fire && (tail == TAG_WIDTH'(i))) begin
          valid_q[i]    <= 1'b1;
          complete_q[i] <= 1'b0;
        end else if (retire_fire && (head == TAG_WIDTH'(i))) begin
          valid_q[i]    <= 1'b0;
          complete_q[i] <= 1'b0;
        end else if (wb_hit[i]) begin
          complete_q[i] <= 1'b1;
        end
      end
    end
  end

  // Payload storage is only meaningful while valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      has_rd_q[tail]   <= alloc_has_rd;
      areg_q[tail]     <= alloc_areg;
      preg_q[tail]     <= alloc_preg;
      old_preg_q[tail] <= alloc_old_preg;
      pc_q[tail]       <= alloc_pc;
    end
  end

  // Registered retire port: one pulse per retired entry, data holds between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_valid     <= 1'b0;
      commit_has_rd    <= 1'b0;
      commit_areg      <= '0;
      commit_preg      <= '0;
      commit_free_preg <= '0;
      commit_pc        <= '0;
    end else begin
      commit_valid <= retire_fire;
      if (retire_fire) begin
        commit_has_rd    <= has_rd_q[head];
        commit_areg      <= areg_q[head];
        commit_preg      <= preg_q[head];
        commit_free_preg <= old_preg_q[head];
        commit_pc        <= pc_q[head];
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed vector table, multi-cycle corner sequences and a queue-based random model.
module tb_rob;

  localparam int PW = 6;
  localparam int AW = 5;
  localparam int CW = 12;
  localparam int N  = 16;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid;
  logic          alloc_ready;
  logic          alloc_has_rd;
  logic [AW-1:0] alloc_areg;
  logic [PW-1:0] alloc_preg;
  logic [PW-1:0] alloc_old_preg;
  logic [CW-1:0] alloc_pc;
  logic [TW-1:0] alloc_tag;
  logic          wb0_valid;
  logic          wb1_valid;
  logic [TW-1:0] wb0_tag;
  logic [TW-1:0] wb1_tag;
  logic          commit_valid;
  logic          commit_has_rd;
  logic [AW-1:0] commit_areg;
  logic [PW-1:0] commit_preg;
  logic [PW-1:0] commit_free_preg;
  logic [CW-1:0] commit_pc;
  logic [TW:0]   count;
  logic          empty;

  rob #(
    .PREG_WIDTH (PW),
    .AREG_WIDTH (AW),
    .PC_WIDTH   (CW),
    .ENTRIES    (N),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_valid      (alloc_valid),
    .alloc_ready      (alloc_ready),
    .alloc_has_rd     (alloc_has_rd),
    .alloc_areg       (alloc_areg),
    .alloc_preg       (alloc_preg),
    .alloc_old_preg   (alloc_old_preg),
    .alloc_pc         (alloc_pc),
    .alloc_tag        (alloc_tag),
    .wb0_valid        (wb0_valid),
    .wb1_valid        (wb1_valid),
    .wb0_tag          (wb0_tag),
    .wb1_tag          (wb1_tag),
    .commit_valid     (commit_valid),
    .commit_has_rd    (commit_has_rd),
    .commit_areg      (commit_areg),
    .commit_preg      (commit_preg),
    .commit_free_preg (commit_free_preg),
    .commit_pc        (commit_pc),
    .count            (count),
    .empty            (empty)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [TW-1:0] tag;
    logic          done;
    logic          has_rd;
    logic [AW-1:0] areg;
    logic [PW-1:0] preg;
    logic [PW-1:0] old_preg;
    logic [CW-1:0] pc;
  } ent_t;

  ent_t q[$];
  int   m_tail;
  ent_t last;

  typedef struct {
    bit            rst_first;
    bit            av;
    logic [AW-1:0] areg;
    logic [PW-1:0] preg;
    logic [PW-1:0] old_preg;
    logic [CW-1:0] pc;
    bit            w0v;
    logic [TW-1:0] w0t;
    bit            w1v;
    logic [TW-1:0] w1t;
    bit            e_cv;
    logic [PW-1:0] e_preg;
    logic [PW-1:0] e_free;
    logic [CW-1:0] e_pc;
    int            e_count;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input bit av, input bit hrd, input logic [AW-1:0] ar,
                                input logic [PW-1:0] pr, input logic [PW-1:0] op,
                                input logic [CW-1:0] pc, input bit w0v, input logic [TW-1:0] w0t,
                                input bit w1v, input logic [TW-1:0] w1t);
    alloc_valid    = av;
    alloc_has_rd   = hrd;
    alloc_areg     = ar;
    alloc_preg     = pr;
    alloc_old_preg = op;
    alloc_pc       = pc;
    wb0_valid      = w0v;
    wb0_tag        = w0t;
    wb1_valid      = w1v;
    wb1_tag        = w1t;
  endtask

  task automatic model_clear();
    q.delete();
    m_tail = 0;
    last   = '{tag: '0, done: 1'b0, has_rd: 1'b0, areg: '0, preg: '0, old_preg: '0, pc: '0};
  endtask

  task automatic do_reset();
    apply_stimulus(0, 0, '0, '0, '0, '0, 0, '0, 0, '0);
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
  endtask

  // One clock of the model: checks pre-edge status, predicts retire/writeback/alloc, then checks the commit port.
  task automatic step();
    bit   accept;
    bit   ret;
    ent_t e;
    check_output("alloc_ready", 32'(alloc_ready), 32'(q.size() < N));
    check_output("count", 32'(count), 32'(q.size()));
    check_output("empty", 32'(empty), 32'(q.size() == 0));
    check_output("alloc_tag", 32'(alloc_tag), 32'(m_tail));
    accept = alloc_valid && (q.size() < N);
    ret    = (q.size() > 0) && q[0].done;
    if (ret) begin
      last = q[0];
      void'(q.pop_front());
    end
    foreach (q[i]) begin
      if ((wb0_valid && q[i].tag == wb0_tag) || (wb1_valid && q[i].tag == wb1_tag))
        q[i].done = 1'b1;
    end
    if (accept) begin
      e.tag      = TW'(m_tail);
      e.done     = 1'b0;
      e.has_rd   = alloc_has_rd;
      e.areg     = alloc_areg;
      e.preg     = alloc_preg;
      e.old_preg = alloc_old_preg;
      e.pc       = alloc_pc;
      q.push_back(e);
      m_tail = (m_tail + 1) % N;
    end
    @(posedge clk);
    #1;
    check_output("commit_valid", 32'(commit_valid), 32'(ret));
    check_output("commit_has_rd", 32'(commit_has_rd), 32'(last.has_rd));
    check_output("commit_areg", 32'(commit_areg), 32'(last.areg));
    check_output("commit_preg", 32'(commit_preg), 32'(last.preg));
    check_output("commit_free_preg", 32'(commit_free_preg), 32'(last.old_preg));
    check_output("commit_pc", 32'(commit_pc), 32'(last.pc));
  endtask

  task automatic alloc_step(input logic [CW-1:0] pc);
    apply_stimulus(1, $urandom_range(0, 1) == 1, AW'($urandom), PW'($urandom), PW'($urandom), pc,
                   0, '0, 0, '0);
    step();
  endtask

  function automatic vec_t mk(bit rf, bit av, int ar, int pr, int op, int pc,
                              bit w0v, int w0t, bit w1v, int w1t,
                              bit ecv, int epr, int efr, int epc, int ecnt);
    vec_t v;
    v.rst_first = rf;  v.av = av;
    v.areg = AW'(ar);  v.preg = PW'(pr); v.old_preg = PW'(op); v.pc = CW'(pc);
    v.w0v = w0v;       v.w0t = TW'(w0t); v.w1v = w1v; v.w1t = TW'(w1t);
    v.e_cv = ecv;      v.e_preg = PW'(epr); v.e_free = PW'(efr); v.e_pc = CW'(epc);
    v.e_count = ecnt;
    return v;
  endfunction

  initial begin
    rst = 1'b0;
    model_clear();
    apply_stimulus(0, 0, '0, '0, '0, '0, 0, '0, 0, '0);
    #1;
    check_output("reset_commit_valid", 32'(commit_valid), 32'd0);
    check_output("reset_count", 32'(count), 32'd0);
    check_output("reset_empty", 32'(empty), 32'd1);
    check_output("reset_alloc_ready", 32'(alloc_ready), 32'd1);
    check_output("reset_alloc_tag", 32'(alloc_tag), 32'd0);
    check_output("reset_commit_preg", 32'(commit_preg), 32'd0);

    // In-order completion: three consecutive retires.
    vecs.push_back(mk(1, 1, 1, 33, 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 34, 2, 'h104, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 3, 35, 3, 'h108, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 33, 1, 'h100, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 34, 2, 'h104, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 35, 3, 'h108, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Out-of-order completion: nothing retires until the head completes.
    vecs.push_back(mk(1, 1, 4, 40, 4, 'h200, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 5, 41, 5, 'h204, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 6, 42, 6, 'h208, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 40, 4, 'h200, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 41, 5, 'h204, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 42, 6, 'h208, 0));
    // Dual writeback to one tag, then a writeback to an empty slot.
    vecs.push_back(mk(1, 1, 7, 50, 7, 'h300, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 8, 51, 8, 'h304, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 50, 7, 'h300, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 51, 8, 'h304, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      if (vecs[k].rst_first) do_reset();
      apply_stimulus(vecs[k].av, 1'b1, vecs[k].areg, vecs[k].preg, vecs[k].old_preg, vecs[k].pc,
                     vecs[k].w0v, vecs[k].w0t, vecs[k].w1v, vecs[k].w1t);
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d_commit_valid", k), 32'(commit_valid), 32'(vecs[k].e_cv));
      check_output($sformatf("vec%0d_count", k), 32'(count), 32'(vecs[k].e_count));
      if (vecs[k].e_cv) begin
        check_output($sformatf("vec%0d_commit_preg", k), 32'(commit_preg), 32'(vecs[k].e_preg));
        check_output($sformatf("vec%0d_commit_free_preg", k), 32'(commit_free_preg), 32'(vecs[k].e_free));
        check_output($sformatf("vec%0d_commit_pc", k), 32'(commit_pc), 32'(vecs[k].e_pc));
      end
    end

    // Full buffer: 17th alloc refused, slot reopens only after the retire edge, tail wraps to 0.
    do_reset();
    for (int i = 0; i < N; i++) alloc_step(CW'(i + 'h400));
    check_output("full_count", 32'(count), 32'd16);
    check_output("full_alloc_ready", 32'(alloc_ready), 32'd0);
    apply_stimulus(1, 1, 5'd9, 6'd9, 6'd9, 12'hABC, 1, 4'd0, 0, '0);
    step();
    check_output("full_refused_count", 32'(count), 32'd16);
    apply_stimulus(1, 1, 5'd9, 6'd9, 6'd9, 12'hABC, 0, '0, 0, '0);
    step();
    check_output("full_reopen_ready", 32'(alloc_ready), 32'd1);
    check_output("full_reopen_tag", 32'(alloc_tag), 32'd0);
    check_output("full_retired_pc", 32'(commit_pc), 32'h400);
    step();
    check_output("full_again_ready", 32'(alloc_ready), 32'd0);

    // Steady state: one alloc and one retire per cycle across pointer wrap.
    do_reset();
    for (int i = 0; i < 4; i++) alloc_step(CW'(i + 'h500));
    apply_stimulus(0, 0, '0, '0, '0, '0, 1, 4'd0, 0, '0);
    step();
    for (int k = 1; k <= 40; k++) begin
      apply_stimulus(1, 1, AW'(k), PW'(k), PW'(k + 1), CW'(k + 'h600), 1, TW'(k % N), 0, '0);
      step();
      check_output("steady_count", 32'(count), 32'd4);
    end

    // Reset while a commit pulse is up with work pending.
    do_reset();
    for (int i = 0; i < 6; i++) alloc_step(CW'(i + 'h700));
    apply_stimulus(0, 0, '0, '0, '0, '0, 1, 4'd0, 0, '0);
    step();
    apply_stimulus(0, 0, '0, '0, '0, '0, 0, '0, 0, '0);
    step();
    rst = 1'b0;
    #1;
    check_output("midrst_commit_valid", 32'(commit_valid), 32'd0);
    check_output("midrst_count", 32'(count), 32'd0);
    check_output("midrst_empty", 32'(empty), 32'd1);
    check_output("midrst_commit_pc", 32'(commit_pc), 32'd0);
    #1;
    rst = 1'b1;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0, 0, '0, '0, '0, '0, 1, TW'(i), 1, TW'(5 - i));
      step();
    end

    // Randomized traffic checked against the queue model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      bit            av;
      bit            w0v;
      bit            w1v;
      logic [TW-1:0] w0t;
      logic [TW-1:0] w1t;
      av  = $urandom_range(0, 99) < 55;
      w0v = 0; w0t = TW'($urandom);
      w1v = 0; w1t = TW'($urandom);
      if (q.size() > 0 && $urandom_range(0, 99) < 50) begin
        w0v = 1; w0t = q[$urandom_range(0, q.size() - 1)].tag;
      end else if ($urandom_range(0, 99) < 15) begin
        w0v = 1;
      end
      if (q.size() > 0 && $urandom_range(0, 99) < 35) begin
        w1v = 1; w1t = q[$urandom_range(0, q.size() - 1)].tag;
      end else if ($urandom_range(0, 99) < 10) begin
        w1v = 1;
      end
      apply_stimulus(av, $urandom_range(0, 1) == 1, AW'($urandom), PW'($urandom), PW'($urandom),
                     CW'($urandom), w0v, w0t, w1v, w1t);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
